// File: rtl/uart_apb_csr.sv
// uart_apb_csr: APB register block for the UART with TX/RX FIFOs, busy handshake to the TX engine,
// sticky write-1-to-clear error flags, FIFO flush, fill-level readback and one maskable level IRQ.
module uart_apb_csr #(
  parameter int                FIFO_DEPTH = 16,
  parameter int                BAUD_W     = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST   = '0
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [7:0]        pAddr,
  input  logic [31:0]       pWdata,
  output logic [31:0]       pRdata,
  input  logic              TxDone,
  input  logic              RxDone,
  input  logic [7:0]        RxData,
  input  logic              RxStopBit,
  input  logic              RxParityErr,
  output logic              TxStart,
  output logic [7:0]        TxData,
  output logic [BAUD_W-1:0] BaudDiv,
  output logic [4:0]        Cfg,
  output logic              IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [9:0]        ctrl_q, ctrl_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        err_q, err_d, err_set, err_clr;
  logic [7:0]        txdata_q, txdata_d;
  logic              busy_q, busy_d, irq_q, irq_d;
  logic              wr, rd, wr_ctrl, tx_flush, rx_flush, tx_pop, tx_push, rx_pop, rx_push;
  logic              tx_full, rx_full, tx_empty, rx_ne, rx_req, tx_req;
  logic [8:0]        status;
  logic              unused;

  assign wr       = pSel & pEnable & pWrite;
  assign rd       = pSel & pEnable & ~pWrite;
  assign wr_ctrl  = wr & (pAddr == 8'h0C);
  assign tx_full  = tx_cnt_q == FULL;
  assign rx_full  = rx_cnt_q == FULL;
  assign tx_empty = tx_cnt_q == '0;
  assign rx_ne    = rx_cnt_q != '0;
  assign tx_flush = wr_ctrl & pWdata[10];
  assign rx_flush = wr_ctrl & pWdata[11];
  assign tx_req   = wr & (pAddr == 8'h00);
  assign rx_req   = RxDone & ctrl_q[1];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign tx_pop   = ctrl_q[0] & ~busy_q & ~tx_empty & ~tx_flush;
  assign tx_push  = tx_req & (~tx_full | tx_pop) & ~tx_flush;
  assign rx_pop   = rd & (pAddr == 8'h04) & rx_ne;
  assign rx_push  = rx_req & (~rx_full | rx_pop) & ~rx_flush;
  assign err_set  = {tx_req & tx_full & ~tx_pop & ~tx_flush,
                     rx_req & rx_full & ~rx_pop & ~rx_flush,
                     rx_push & RxParityErr,
                     rx_push & ~RxStopBit};
  assign err_clr  = (wr & (pAddr == 8'h10)) ? pWdata[7:4] : 4'b0;
  assign status   = {busy_q, err_q, rx_full, tx_full, tx_empty & ~busy_q, rx_ne};
  assign unused   = ^pWdata[31:12];

  always_comb begin
    tx_wp_d  = tx_flush ? '0 : tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_flush ? '0 : tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_flush ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_flush ? '0 : rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_flush ? '0 : rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_flush ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    busy_d   = tx_pop | (busy_q & ~TxDone);
    txdata_d = tx_pop ? tx_mem[tx_rp_q] : txdata_q;
    ctrl_d   = wr_ctrl ? pWdata[9:0] : ctrl_q;
    baud_d   = (wr & (pAddr == 8'h08)) ? pWdata[BAUD_W-1:0] : baud_q;
    err_d    = (err_q & ~err_clr) | err_set;
    irq_d    = (ctrl_q[2] & tx_empty) | (ctrl_q[3] & rx_ne) | (ctrl_q[4] & |err_q);
  end

  always_comb begin
    pRdata = '0;
    if (rd)
      pRdata = (pAddr == 8'h04) ? {24'b0, rx_ne ? rx_mem[rx_rp_q] : 8'h00} :
               (pAddr == 8'h08) ? 32'(baud_q) :
               (pAddr == 8'h0C) ? {22'b0, ctrl_q} :
               (pAddr == 8'h10) ? {23'b0, status} :
               (pAddr == 8'h14) ? {8'b0, 8'(tx_cnt_q), 8'b0, 8'(rx_cnt_q)} : 32'b0;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      busy_q   <= 1'b0;
      txdata_q <= '0;
      ctrl_q   <= '0;
      baud_q   <= BAUD_RST;
      err_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      busy_q   <= busy_d;
      txdata_q <= txdata_d;
      ctrl_q   <= ctrl_d;
      baud_q   <= baud_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: the counts alone decide which entries are live.
  always_ff @(posedge pClk) begin
    if (tx_push) tx_mem[tx_wp_q] <= pWdata[7:0];
    if (rx_push) rx_mem[rx_wp_q] <= RxData;
  end

  assign TxStart = tx_pop;
  assign TxData  = txdata_q;
  assign BaudDiv = baud_q;
  assign Cfg     = ctrl_q[9:5];
  assign IRQ     = irq_q;
endmodule

// File: tb/tb_uart_apb_csr.sv
// tb_uart_apb_csr: directed + randomized bench for uart_apb_csr against a queue-based reference model.
module tb_uart_apb_csr;
  localparam int DEPTH = 16;
  localparam logic [15:0] BRST = 16'h1234;

  logic        pClk, pReset, pSel, pEnable, pWrite;
  logic [7:0]  pAddr;
  logic [31:0] pWdata, pRdata;
  logic        TxDone, RxDone, RxStopBit, RxParityErr, TxStart, IRQ;
  logic [7:0]  RxData, TxData;
  logic [15:0] BaudDiv;
  logic [4:0]  Cfg;

  int total = 0;
  int bad = 0;

  uart_apb_csr #(.FIFO_DEPTH(DEPTH), .BAUD_W(16), .BAUD_RST(BRST)) dut (
    .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pRdata(pRdata), .TxDone(TxDone), .RxDone(RxDone),
    .RxData(RxData), .RxStopBit(RxStopBit), .RxParityErr(RxParityErr), .TxStart(TxStart),
    .TxData(TxData), .BaudDiv(BaudDiv), .Cfg(Cfg), .IRQ(IRQ)
  );

  initial begin
    pClk = 0;
    forever #5 pClk = ~pClk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, registers as plain variables.
  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [9:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [3:0]  m_err;
  logic [7:0]  m_txdata;
  logic        m_busy, m_irq;

  function automatic void m_reset();
    m_txq.delete();
    m_rxq.delete();
    m_ctrl = 0; m_baud = BRST; m_err = 0; m_txdata = 0; m_busy = 0; m_irq = 0;
  endfunction

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    int tn = m_txq.size();
    int rn = m_rxq.size();
    case (a)
      8'h04: return (rn > 0) ? {24'b0, m_rxq[0]} : 32'b0;
      8'h08: return {16'b0, m_baud};
      8'h0C: return {22'b0, m_ctrl};
      8'h10: return {23'b0, m_busy, m_err, rn == DEPTH, tn == DEPTH, tn == 0 && !m_busy, rn > 0};
      8'h14: return (tn << 16) | rn;
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic m_flush(input int bitn);
    return pSel && pEnable && pWrite && pAddr == 8'h0C && pWdata[bitn];
  endfunction

  function automatic logic m_start();
    return m_ctrl[0] && !m_busy && m_txq.size() > 0 && !m_flush(10);
  endfunction

  function automatic void m_step();
    logic w = pSel && pEnable && pWrite;
    logic r = pSel && pEnable && !pWrite;
    logic [3:0] set = 0;
    logic [3:0] clr = (w && pAddr == 8'h10) ? pWdata[7:4] : 4'b0;
    logic irq_n = (m_ctrl[2] && m_txq.size() == 0) || (m_ctrl[3] && m_rxq.size() > 0) ||
                  (m_ctrl[4] && m_err != 0);
    if (m_start()) begin
      m_txdata = m_txq.pop_front();
      m_busy = 1;
    end else if (TxDone) m_busy = 0;
    if (m_flush(10)) m_txq.delete();
    else if (w && pAddr == 8'h00) begin
      if (m_txq.size() < DEPTH) m_txq.push_back(pWdata[7:0]);
      else set[3] = 1;
    end
    if (r && pAddr == 8'h04 && m_rxq.size() > 0) void'(m_rxq.pop_front());
    if (m_flush(11)) m_rxq.delete();
    else if (RxDone && m_ctrl[1]) begin
      if (m_rxq.size() < DEPTH) begin
        m_rxq.push_back(RxData);
        set[0] = !RxStopBit;
        set[1] = RxParityErr;
      end else set[2] = 1;
    end
    m_err = (m_err & ~clr) | set;
    if (w && pAddr == 8'h0C) m_ctrl = pWdata[9:0];
    if (w && pAddr == 8'h08) m_baud = pWdata[15:0];
    m_irq = irq_n;
  endfunction

  // Compare process: mid-cycle, inputs are stable and outputs settled.
  initial forever begin
    @(negedge pClk);
    if (!pReset) m_reset();
    chk("txstart", {31'b0, TxStart}, {31'b0, m_start()});
    chk("txdata", {24'b0, TxData}, {24'b0, m_txdata});
    chk("irq", {31'b0, IRQ}, {31'b0, m_irq});
    chk("bauddiv", {16'b0, BaudDiv}, {16'b0, m_baud});
    chk("cfg", {27'b0, Cfg}, {27'b0, m_ctrl[9:5]});
    chk("prdata", pRdata, (pSel && pEnable && !pWrite) ? m_reg(pAddr) : 32'b0);
    if (pReset) m_step();
  end

  task automatic begin_cycle();
    @(posedge pClk);
    #2;
    pSel = 0; pEnable = 0; TxDone = 0; RxDone = 0;
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] rd);
    begin_cycle();
    pSel = 1; pWrite = w; pAddr = a; pWdata = d;
    begin_cycle();
    pSel = 1; pEnable = 1;
    #2 rd = pRdata;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] x;
    apb(1'b1, a, d, x);
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    apb(1'b0, a, 32'b0, d);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    begin_cycle();
    RxDone = 1; RxData = b; RxStopBit = stop; RxParityErr = 0;
  endtask

  initial begin
    logic [31:0] d;
    pReset = 0; pSel = 0; pEnable = 0; pWrite = 0; pAddr = 0; pWdata = 0;
    TxDone = 0; RxDone = 0; RxData = 0; RxStopBit = 1; RxParityErr = 0;
    repeat (2) @(posedge pClk);
    begin_cycle();
    pReset = 1;
    #1;
    chk("rst_irq", {31'b0, IRQ}, 0);
    chk("rst_txstart", {31'b0, TxStart}, 0);
    chk("rst_bauddiv", {16'b0, BaudDiv}, 32'h1234);
    apb_rd(8'h00, d); chk("rst_txdata_rd", d, 0);
    apb_rd(8'h04, d); chk("rst_rxdata_rd", d, 0);
    apb_rd(8'h08, d); chk("rst_baud_rd", d, 32'h1234);
    apb_rd(8'h0C, d); chk("rst_ctrl_rd", d, 0);
    apb_rd(8'h10, d); chk("rst_status_rd", d, 32'h002);
    apb_rd(8'h14, d); chk("rst_level_rd", d, 0);

    apb_wr(8'h0C, 1);
    apb_wr(8'h00, 8'hA5);
    begin_cycle(); #1 chk("tx1_start", {31'b0, TxStart}, 1);
    begin_cycle(); #1 chk("tx1_data", {24'b0, TxData}, 8'hA5);
    chk("tx1_single_pulse", {31'b0, TxStart}, 0);
    apb_wr(8'h00, 8'h3C);
    apb_rd(8'h10, d); chk("tx_busy_status", d, 32'h100);
    begin_cycle(); TxDone = 1;
    begin_cycle(); #1 chk("tx2_start", {31'b0, TxStart}, 1);
    begin_cycle(); #1 chk("tx2_data", {24'b0, TxData}, 8'h3C);
    begin_cycle(); TxDone = 1;
    repeat (2) begin_cycle();
    apb_rd(8'h10, d); chk("tx_idle_status", d, 32'h002);

    apb_wr(8'h0C, 0);
    for (int i = 0; i < 17; i++) apb_wr(8'h00, i);
    apb_rd(8'h14, d); chk("txfull_level", d, 32'h0010_0000);
    apb_rd(8'h10, d); chk("txfull_status", d, 32'h084);
    apb_wr(8'h10, 32'h80);
    apb_rd(8'h10, d); chk("txovr_w1c", d, 32'h004);
    apb_wr(8'h0C, 32'h400);
    apb_rd(8'h14, d); chk("txflush_level", d, 0);

    apb_wr(8'h0C, 32'h12);
    for (int i = 0; i < 17; i++) rx_byte(8'h10 + 8'(i), i != 2);
    begin_cycle();
    RxStopBit = 1;
    begin_cycle(); #1 chk("rx_err_irq", {31'b0, IRQ}, 1);
    apb_rd(8'h14, d); chk("rxfull_level", d, 32'h10);
    apb_rd(8'h10, d); chk("rxfull_status", d, 32'h05B);
    for (int i = 0; i < 16; i++) begin
      apb_rd(8'h04, d); chk("rx_order", d, 32'h10 + i);
    end
    apb_rd(8'h04, d); chk("rx_empty_rd", d, 0);

    apb_wr(8'h10, 32'hF0);
    for (int i = 0; i < 16; i++) rx_byte(8'h40 + 8'(i), 1);
    begin_cycle();
    pSel = 1; pWrite = 0; pAddr = 8'h04;
    begin_cycle();
    pSel = 1; pEnable = 1; RxDone = 1; RxData = 8'h77;
    #2 chk("simul_rd", pRdata, 32'h40);
    apb_rd(8'h14, d); chk("simul_level", d, 32'h10);
    apb_rd(8'h10, d); chk("simul_status", d, 32'h00B);
    for (int i = 0; i < 16; i++) apb_rd(8'h04, d);
    chk("simul_last", d, 32'h77);

    apb_wr(8'h0C, 32'h3A0);
    apb_wr(8'h08, 32'hBEEF);
    begin_cycle(); #1 chk("cfg_out", {27'b0, Cfg}, 32'h1D);
    chk("baud_out", {16'b0, BaudDiv}, 32'hBEEF);

    apb_wr(8'h0C, 1);
    for (int i = 0; i < 6; i++) apb_wr(8'h00, 8'hC0 + 8'(i));
    apb_rd(8'h14, d); chk("prerst_level", d, 32'h0005_0000);
    begin_cycle();
    pReset = 0;
    begin_cycle();
    pReset = 1;
    #1 chk("midrst_txstart", {31'b0, TxStart}, 0);
    apb_rd(8'h14, d); chk("midrst_level", d, 0);
    apb_rd(8'h10, d); chk("midrst_status", d, 32'h002);
    apb_wr(8'h0C, 1);
    begin_cycle(); TxDone = 1;
    begin_cycle(); #1 chk("midrst_no_start", {31'b0, TxStart}, 0);
    apb_wr(8'h00, 8'h99);
    begin_cycle(); #1 chk("midrst_busy_clear", {31'b0, TxStart}, 1);

    for (int i = 0; i < 3000; i++) begin
      begin_cycle();
      if (i == 1500) pReset = 0;
      if (i == 1501) pReset = 1;
      TxDone = ($urandom % 6) == 0;
      RxDone = ($urandom % 4) == 0;
      RxData = 8'($urandom);
      RxStopBit = ($urandom % 8) != 0;
      RxParityErr = ($urandom % 8) == 0;
      if ($urandom % 2) begin
        pSel = 1;
        pEnable = ($urandom % 4) != 0;
        pWrite = $urandom % 2;
        case ($urandom % 9)
          0, 1: pAddr = 8'h00;
          2, 3: pAddr = 8'h04;
          4: pAddr = 8'h08;
          5: pAddr = 8'h0C;
          6: pAddr = 8'h10;
          7: pAddr = 8'h14;
          default: pAddr = 8'($urandom);
        endcase
        pWdata = $urandom;
        if (pAddr == 8'h0C) begin
          pWdata[11:10] = (($urandom % 8) == 0) ? 2'($urandom) : 2'b00;
          pWdata[1:0] = {1'(($urandom % 4) != 0), 1'(($urandom % 4) != 0)};
        end
      end
    end
    repeat (3) begin_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
